// File: rtl/video_pkg.sv
// Shared definitions for the video capture/DMA blocks: AXI field constants,
// the write-DMA state encoding, video timing defaults and a width helper.
package video_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned H_ACT     = 1280;
  localparam int unsigned V_ACT     = 720;
  localparam int unsigned PIX_BYTES = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAw,
    StW,
    StB
  } dma_state_e;

  // Smallest n with 2**n >= value; usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/frame_wr_dma_if.sv
// AXI4 write-address, write-data and write-response channels as driven by a
// write-only master such as the frame write DMA.
interface frame_wr_dma_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 256
);

  logic [3:0]          m_awid;
  logic [ADDR_W-1:0]   m_awaddr;
  logic [7:0]          m_awlen;
  logic [2:0]          m_awsize;
  logic [1:0]          m_awburst;
  logic                m_awvalid;
  logic                m_awready;

  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wlast;
  logic                m_wvalid;
  logic                m_wready;

  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;

  modport master (
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready
  );

endinterface

// File: rtl/vs_edge_sync.sv
// Three-flop synchroniser for an asynchronous level with a one-cycle pulse on
// its rising edge (taken between the second and third flops).
module vs_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/frame_wr_dma.sv
// Single-channel video write DMA: on each source VSYNC latches a frame base
// address and drains the line FIFO to DDR in fixed-length AXI4 INCR bursts.
module frame_wr_dma #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned H_ACT     = video_pkg::H_ACT,
  parameter int unsigned V_ACT     = video_pkg::V_ACT,
  parameter int unsigned PIX_BYTES = video_pkg::PIX_BYTES,
  parameter int unsigned AXI_ID    = 0
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              frame_vs,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic [9:0]        fifo_rd_cnt,
  output logic              fifo_rd_en,
  output logic              fifo_clr,
  frame_wr_dma_if.master    m_axi,
  output logic              frame_done,
  output logic              wr_err
);

  import video_pkg::*;

  localparam int unsigned BEAT_BYTES   = DATA_W / 8;
  localparam int unsigned BURST_BYTES  = BURST_LEN * BEAT_BYTES;
  localparam int unsigned FRAME_BYTES  = H_ACT * V_ACT * PIX_BYTES;
  localparam int unsigned FRAME_BURSTS = FRAME_BYTES / BURST_BYTES;
  localparam int unsigned CNT_W        = clog2(FRAME_BURSTS + 1);
  localparam int unsigned AW_SIZE      = clog2(BEAT_BYTES);

  if (BURST_LEN < 1 || BURST_LEN > 256) begin : gen_bad_burst_len
    $error("frame_wr_dma: BURST_LEN must lie in 1..256");
  end
  if (FRAME_BURSTS == 0 || (FRAME_BYTES % BURST_BYTES) != 0) begin : gen_bad_frame_size
    $error("frame_wr_dma: frame size is not a whole number of bursts");
  end

  dma_state_e        state_q;
  logic              start_pend_q;
  logic              frame_act_q;
  logic [ADDR_W-1:0] frame_base_q;
  logic [CNT_W-1:0]  burst_cnt_q;
  logic [8:0]        beat_q;
  logic              awvalid_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic              wvalid_q;
  logic              wlast_q;
  logic              bready_q;
  logic              fifo_clr_q;
  logic              frame_done_q;
  logic              wr_err_q;

  logic              vs_pos;
  logic              start_take;
  logic              burst_ready;
  logic [ADDR_W-1:0] burst_off;

  vs_edge_sync u_vs_sync (
    .clk      (axi_aclk),
    .rst      (axi_areset),
    .async_in (frame_vs),
    .rise     (vs_pos)
  );

  assign start_take  = (state_q == StIdle) & start_pend_q;
  assign burst_ready = 32'(fifo_rd_cnt) >= BURST_LEN;
  assign burst_off   = ADDR_W'(32'(burst_cnt_q) * BURST_BYTES);

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q      <= StIdle;
      start_pend_q <= 1'b0;
      frame_act_q  <= 1'b0;
      frame_base_q <= '0;
      burst_cnt_q  <= '0;
      beat_q       <= '0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      fifo_clr_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      fifo_clr_q   <= 1'b0;
      frame_done_q <= 1'b0;
      // A new edge arriving while one is pending simply merges into it.
      start_pend_q <= vs_pos | (start_pend_q & ~start_take);

      unique case (state_q)
        StIdle: begin
          if (start_pend_q) begin
            state_q      <= StStart;
            frame_base_q <= base_addr;
            burst_cnt_q  <= '0;
            fifo_clr_q   <= 1'b1;
            frame_act_q  <= 1'b1;
          end else if (frame_act_q && burst_ready) begin
            state_q   <= StAw;
            awvalid_q <= 1'b1;
            awaddr_q  <= frame_base_q + burst_off;
          end
        end
        StStart: begin
          // Give the FIFO flush a cycle before its count is trusted again.
          state_q <= StIdle;
        end
        StAw: begin
          if (m_axi.m_awready) begin
            state_q   <= StW;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_q    <= '0;
            wlast_q   <= (BURST_LEN == 1);
          end
        end
        StW: begin
          if (m_axi.m_wready) begin
            beat_q  <= beat_q + 9'd1;
            wlast_q <= (32'(beat_q) + 2 == BURST_LEN);
            if (wlast_q) begin
              state_q  <= StB;
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
            end
          end
        end
        StB: begin
          if (m_axi.m_bvalid) begin
            state_q     <= StIdle;
            bready_q    <= 1'b0;
            burst_cnt_q <= burst_cnt_q + 1'b1;
            if (m_axi.m_bresp != RESP_OKAY) begin
              wr_err_q <= 1'b1;
            end
            if (32'(burst_cnt_q) + 1 == FRAME_BURSTS) begin
              frame_act_q  <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_axi.m_awid    = 4'(AXI_ID);
  assign m_axi.m_awaddr  = awaddr_q;
  assign m_axi.m_awlen   = 8'(BURST_LEN - 1);
  assign m_axi.m_awsize  = 3'(AW_SIZE);
  assign m_axi.m_awburst = BURST_INCR;
  assign m_axi.m_awvalid = awvalid_q;

  // First-word-fall-through FIFO: the head word is the beat on offer.
  assign m_axi.m_wdata  = fifo_dout;
  assign m_axi.m_wstrb  = '1;
  assign m_axi.m_wlast  = wlast_q;
  assign m_axi.m_wvalid = wvalid_q;
  assign m_axi.m_bready = bready_q;

  assign fifo_rd_en = wvalid_q & m_axi.m_wready;
  assign fifo_clr   = fifo_clr_q;
  assign frame_done = frame_done_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_frame_wr_dma.sv
// Directed bench for frame_wr_dma with a reduced frame (1280x8x2 bytes = 40
// bursts of 512 bytes), an AXI slave responder and a FIFO data model.
module tb_frame_wr_dma;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned BL     = 16;
  localparam int unsigned FB     = 40;

  logic              clk = 1'b0;
  logic              axi_areset;
  logic              frame_vs;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] fifo_dout;
  logic [9:0]        fifo_rd_cnt;
  logic              fifo_rd_en;
  logic              fifo_clr;
  logic              frame_done;
  logic              wr_err;

  frame_wr_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi_bus ();

  frame_wr_dma #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BL),
    .H_ACT     (1280),
    .V_ACT     (8),
    .PIX_BYTES (2),
    .AXI_ID    (0)
  ) dut (
    .axi_aclk    (clk),
    .axi_areset  (axi_areset),
    .frame_vs    (frame_vs),
    .base_addr   (base_addr),
    .fifo_dout   (fifo_dout),
    .fifo_rd_cnt (fifo_rd_cnt),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_clr    (fifo_clr),
    .m_axi       (axi_bus),
    .frame_done  (frame_done),
    .wr_err      (wr_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [DATA_W-1:0] pat(input int unsigned i);
    return {8{i}};
  endfunction

  // FIFO model and bus monitor
  int unsigned       word_idx = 0;
  int unsigned       exp_idx  = 0;
  int unsigned       pos      = 0;
  int                aw_cnt = 0, b_done = 0, b_owed = 0, wlast_cnt = 0, beat_acc = 0;
  int                done_cnt = 0, clr_cnt = 0;
  int                bad_data = 0, bad_last = 0, bad_rden = 0, unstable = 0;
  logic [ADDR_W-1:0] last_awaddr = '0;
  logic              prev_aw_stall = 1'b0, prev_w_stall = 1'b0;
  logic [ADDR_W-1:0] prev_awaddr = '0;
  logic [DATA_W-1:0] prev_wdata = '0;
  logic              prev_wlast = 1'b0;

  assign fifo_dout = pat(word_idx);

  always @(posedge clk) begin
    if (fifo_rd_en) word_idx <= word_idx + 1;
    if (fifo_rd_en !== (axi_bus.m_wvalid & axi_bus.m_wready)) bad_rden <= bad_rden + 1;
    if (axi_bus.m_awvalid && axi_bus.m_awready) begin
      aw_cnt      <= aw_cnt + 1;
      last_awaddr <= axi_bus.m_awaddr;
    end
    if (prev_aw_stall && (!axi_bus.m_awvalid || axi_bus.m_awaddr !== prev_awaddr))
      unstable <= unstable + 1;
    if (prev_w_stall && (!axi_bus.m_wvalid || axi_bus.m_wdata !== prev_wdata ||
                         axi_bus.m_wlast !== prev_wlast))
      unstable <= unstable + 1;
    prev_aw_stall <= axi_bus.m_awvalid & ~axi_bus.m_awready;
    prev_w_stall  <= axi_bus.m_wvalid & ~axi_bus.m_wready;
    prev_awaddr   <= axi_bus.m_awaddr;
    prev_wdata    <= axi_bus.m_wdata;
    prev_wlast    <= axi_bus.m_wlast;
    if (axi_bus.m_wvalid && axi_bus.m_wready) begin
      beat_acc <= beat_acc + 1;
      exp_idx  <= exp_idx + 1;
      if (axi_bus.m_wdata !== pat(exp_idx)) bad_data <= bad_data + 1;
      if (axi_bus.m_wlast !== (pos == BL - 1)) bad_last <= bad_last + 1;
      if (axi_bus.m_wlast) begin
        pos       <= 0;
        wlast_cnt <= wlast_cnt + 1;
        b_owed    <= b_owed + 1;
      end else begin
        pos <= pos + 1;
      end
    end
    if (axi_bus.m_bvalid && axi_bus.m_bready) b_done <= b_done + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
    if (fifo_clr) clr_cnt <= clr_cnt + 1;
  end

  // AXI slave responder
  logic stall     = 1'b0;
  int   b_issued  = 0;
  int   err_burst = -1;

  initial begin
    axi_bus.m_awready = 1'b0;
    axi_bus.m_wready  = 1'b0;
    axi_bus.m_bvalid  = 1'b0;
    axi_bus.m_bresp   = 2'b00;
  end

  always @(negedge clk) begin
    axi_bus.m_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    axi_bus.m_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    if (axi_bus.m_bvalid && b_done == b_issued) axi_bus.m_bvalid = 1'b0;
    if (!axi_bus.m_bvalid && b_owed > b_issued && (!stall || $urandom_range(0, 2) == 0)) begin
      axi_bus.m_bresp  = (b_issued == err_burst) ? 2'b10 : 2'b00;
      axi_bus.m_bvalid = 1'b1;
      b_issued         = b_issued + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_vs();
    frame_vs = 1'b1;
    repeat (4) @(negedge clk);
    frame_vs = 1'b0;
  endtask

  initial begin
    axi_areset  = 1'b1;
    frame_vs    = 1'b0;
    base_addr   = '0;
    fifo_rd_cnt = '0;
    repeat (4) @(negedge clk);
    check("rst_awvalid", 64'(axi_bus.m_awvalid), 0);
    check("rst_wvalid", 64'(axi_bus.m_wvalid), 0);
    check("rst_bready", 64'(axi_bus.m_bready), 0);
    check("rst_rd_en", 64'(fifo_rd_en), 0);
    check("rst_clr", 64'(fifo_clr), 0);
    check("rst_done", 64'(frame_done), 0);
    check("rst_err", 64'(wr_err), 0);

    axi_areset  = 1'b0;
    fifo_rd_cnt = 10'd16;
    repeat (20) @(negedge clk);
    check("idle_no_pop", 64'(word_idx), 0);
    check("idle_no_aw", 64'(aw_cnt), 0);

    // First burst of frame 1
    base_addr = 28'h0100000;
    frame_vs  = 1'b1;
    for (int i = 0; i < 12 && clr_cnt == 0; i++) @(negedge clk);
    for (int i = 0; i < 12 && !axi_bus.m_awvalid; i++) @(negedge clk);
    frame_vs = 1'b0;
    check("clr_pulse", 64'(clr_cnt), 1);
    check("aw1_valid", 64'(axi_bus.m_awvalid), 1);
    check("aw1_addr", 64'(axi_bus.m_awaddr), 64'h0100000);
    check("aw1_len", 64'(axi_bus.m_awlen), 15);
    check("aw1_size", 64'(axi_bus.m_awsize), 5);
    check("aw1_burst", 64'(axi_bus.m_awburst), 1);
    check("aw1_id", 64'(axi_bus.m_awid), 0);
    check("aw1_strb", 64'(&axi_bus.m_wstrb), 1);
    for (int i = 0; i < 60 && b_done < 1; i++) @(negedge clk);
    check("b1_wlast_cnt", 64'(wlast_cnt), 1);
    check("b1_beats", 64'(beat_acc), 16);
    check("b1_wlast_pos", 64'(bad_last), 0);

    // Remainder of frame 1, no stalls
    for (int i = 0; i < 2000 && done_cnt < 1; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    check("f1_done", 64'(done_cnt), 1);
    check("f1_aw_cnt", 64'(aw_cnt), FB);
    check("f1_last_addr", 64'(last_awaddr), 64'h0104E00);
    check("f1_pops", 64'(word_idx), FB * BL);
    check("f1_data", 64'(bad_data), 0);
    check("f1_err", 64'(wr_err), 0);

    // Frame 2: random stalls, SLVERR on burst 5
    stall     = 1'b1;
    err_burst = b_issued + 5;
    base_addr = 28'h0200000;
    pulse_vs();
    for (int i = 0; i < 3000 && b_done < FB + 6; i++) @(negedge clk);
    check("f2_err_set", 64'(wr_err), 1);
    check("f2_not_done_yet", 64'(done_cnt), 1);
    for (int i = 0; i < 8000 && done_cnt < 2; i++) @(negedge clk);
    check("f2_done", 64'(done_cnt), 2);
    check("f2_aw_cnt", 64'(aw_cnt), 2 * FB);
    check("f2_last_addr", 64'(last_awaddr), 64'h0204E00);
    check("f2_beats", 64'(beat_acc), 2 * FB * BL);
    check("f2_data", 64'(bad_data), 0);
    check("f2_rd_en", 64'(bad_rden), 0);
    check("f2_stable", 64'(unstable), 0);
    check("f2_wlast_pos", 64'(bad_last), 0);
    check("f2_err_sticky", 64'(wr_err), 1);

    // Frame 3 abandoned during W of burst 10, frame 4 restarts
    stall     = 1'b0;
    base_addr = 28'h0300000;
    pulse_vs();
    for (int i = 0; i < 1000 && aw_cnt < 2 * FB + 11; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("f3_in_w", 64'(axi_bus.m_wvalid), 1);
    base_addr = 28'h0400000;
    pulse_vs();
    for (int i = 0; i < 200 && aw_cnt < 2 * FB + 12; i++) @(negedge clk);
    check("abort_new_base", 64'(last_awaddr), 64'h0400000);
    check("abort_b_done", 64'(b_done), 2 * FB + 11);
    check("abort_beats", 64'(beat_acc), (2 * FB + 11) * BL);
    for (int i = 0; i < 2000 && done_cnt < 3; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    check("f4_done_once", 64'(done_cnt), 3);
    check("f4_aw_cnt", 64'(aw_cnt), 2 * FB + 11 + FB);
    check("f4_last_addr", 64'(last_awaddr), 64'h0404E00);
    check("f4_clr_cnt", 64'(clr_cnt), 4);
    check("f4_data", 64'(bad_data), 0);
    check("f4_err_sticky", 64'(wr_err), 1);

    // FIFO level threshold
    fifo_rd_cnt = 10'd15;
    base_addr   = 28'h0500000;
    pulse_vs();
    repeat (50) @(negedge clk);
    check("lvl15_no_aw", 64'(aw_cnt), 3 * FB + 11);
    check("lvl15_awvalid", 64'(axi_bus.m_awvalid), 0);
    fifo_rd_cnt = 10'd16;
    @(negedge clk);
    check("lvl16_awvalid", 64'(axi_bus.m_awvalid), 1);
    check("lvl16_awaddr", 64'(axi_bus.m_awaddr), 64'h0500000);

    // Reset in the middle of a burst
    for (int i = 0; i < 10 && aw_cnt < 3 * FB + 12; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("mid_in_w", 64'(axi_bus.m_wvalid), 1);
    axi_areset = 1'b1;
    @(negedge clk);
    check("mid_rst_wvalid", 64'(axi_bus.m_wvalid), 0);
    check("mid_rst_awvalid", 64'(axi_bus.m_awvalid), 0);
    check("mid_rst_rd_en", 64'(fifo_rd_en), 0);
    check("mid_rst_err", 64'(wr_err), 0);
    axi_areset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_idle", 64'(aw_cnt), 3 * FB + 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
